// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run_ctrl execution controller.
// The FSM encoding is fixed so the display logic can decode it directly.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT  = 32;
  localparam int ADDR_W_DEFAULT = 32;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/pause/single-step controller gating the PC write-enable, plus statistics.
// Optional PC breakpoint compiled in with RUN_CTRL_BREAKPOINT_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              go,
  input  logic              step_mode,
  input  logic              halt_req,
  input  logic              is_jump,
  input  logic              is_br_taken,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
`endif
  output logic              pc_en,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  cnt_instr,
  output logic [CNT_W-1:0]  cnt_jump,
  output logic [CNT_W-1:0]  cnt_br
);

  state_t state;
  logic   go_q;
  logic   press;
  logic   bp_hit;

  assign press = go & ~go_q;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic skip_bp;

  assign bp_hit = (state == RUN) & bp_valid & (pc == bp_addr) & ~skip_bp;

  // skip_bp lets the trapped instruction execute once on resume
  always_ff @(posedge clk) begin
    if (clr) begin
      skip_bp <= 1'b0;
    end else if ((state == IDLE) && press) begin
      skip_bp <= 1'b1;
    end else if ((state == RUN) || (state == STEP)) begin
      skip_bp <= 1'b0;
    end
  end
`else
  localparam int unused_addr_w = ADDR_W;
  assign bp_hit = 1'b0;
`endif

  assign pc_en   = ((state == RUN) | (state == STEP)) & ~halt_req & ~bp_hit;
  assign running = (state == RUN) | (state == STEP);
  assign halted  = (state == HALT);

  // halt_req outranks both a breakpoint and a pause press in RUN
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      go_q  <= 1'b0;
    end else begin
      go_q <= go;
      case (state)
        IDLE: if (press) state <= step_mode ? STEP : RUN;
        RUN: begin
          if (halt_req)             state <= HALT;
          else if (bp_hit || press) state <= IDLE;
        end
        STEP:    state <= halt_req ? HALT : IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_instr (
    .clk (clk),
    .clr (clr),
    .inc (pc_en),
    .q   (cnt_instr)
  );

  sat_counter #(.W(CNT_W)) u_cnt_jump (
    .clk (clk),
    .clr (clr),
    .inc (pc_en & is_jump),
    .q   (cnt_jump)
  );

  sat_counter #(.W(CNT_W)) u_cnt_br (
    .clk (clk),
    .clr (clr),
    .inc (pc_en & is_br_taken),
    .q   (cnt_br)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl; a second 4-bit-counter instance shares the
// stimulus so counter saturation can be observed quickly.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        clr, go, step_mode, halt_req, is_jump, is_br_taken;
  logic [31:0] pc, bp_addr;
  logic        bp_valid;

  logic        pc_en, running, halted;
  logic [31:0] cnt_instr, cnt_jump, cnt_br;
  logic        pc_en4, running4, halted4;
  logic [3:0]  cnt_instr4, cnt_jump4, cnt_br4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  run_ctrl #(.CNT_W(32), .ADDR_W(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .go          (go),
    .step_mode   (step_mode),
    .halt_req    (halt_req),
    .is_jump     (is_jump),
    .is_br_taken (is_br_taken),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
`endif
    .pc_en       (pc_en),
    .running     (running),
    .halted      (halted),
    .cnt_instr   (cnt_instr),
    .cnt_jump    (cnt_jump),
    .cnt_br      (cnt_br)
  );

  run_ctrl #(.CNT_W(4), .ADDR_W(32)) dut4 (
    .clk         (clk),
    .clr         (clr),
    .go          (go),
    .step_mode   (step_mode),
    .halt_req    (halt_req),
    .is_jump     (is_jump),
    .is_br_taken (is_br_taken),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
`endif
    .pc_en       (pc_en4),
    .running     (running4),
    .halted      (halted4),
    .cnt_instr   (cnt_instr4),
    .cnt_jump    (cnt_jump4),
    .cnt_br      (cnt_br4)
  );

  // Inputs change at the falling edge; the bench always rests on a falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1; go = 1'b0; halt_req = 1'b0; is_jump = 1'b0; is_br_taken = 1'b0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (pc_en !== 1'b0 || running !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: pc_en=%b running=%b required 0/0", i, pc_en, running);
      end
      tick();
    end
    total++;
    if (halted !== 1'b0 || cnt_instr !== 32'd0 || cnt_jump !== 32'd0 || cnt_br !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_counters: halted=%b instr=%0d jump=%0d br=%0d required 0", halted, cnt_instr, cnt_jump, cnt_br);
    end
  endtask

  task automatic test_run_halt();
    do_reset();
    step_mode = 1'b0;
    go = 1'b1;
    #1;
    total++;
    if (pc_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL run_pre_press: pc_en=%b required 0", pc_en);
    end
    tick();
    for (int c = 1; c <= 20; c++) begin
      go       = (c <= 4);
      is_jump  = (c == 3 || c == 8 || c == 15);
      halt_req = (c == 20);
      #1;
      total++;
      if (pc_en !== (c != 20) || running !== 1'b1) begin
        bad++;
        $display("[TB] FAIL run_cycle %0d: pc_en=%b running=%b required %b/1", c, pc_en, running, c != 20);
      end
      tick();
    end
    halt_req = 1'b0; is_jump = 1'b0;
    #1;
    total++;
    if (halted !== 1'b1 || running !== 1'b0 || pc_en !== 1'b0 ||
        cnt_instr !== 32'd19 || cnt_jump !== 32'd3 || cnt_br !== 32'd0) begin
      bad++;
      $display("[TB] FAIL run_halt: halted=%b running=%b pc_en=%b instr=%0d jump=%0d br=%0d required 1/0/0/19/3/0",
               halted, running, pc_en, cnt_instr, cnt_jump, cnt_br);
    end
    for (int p = 0; p < 3; p++) begin
      go = 1'b1; tick();
      go = 1'b0; tick();
    end
    #1;
    total++;
    if (halted !== 1'b1 || pc_en !== 1'b0 || cnt_instr !== 32'd19) begin
      bad++;
      $display("[TB] FAIL halt_sticky: halted=%b pc_en=%b instr=%0d required 1/0/19", halted, pc_en, cnt_instr);
    end
  endtask

  task automatic test_step();
    do_reset();
    step_mode = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      go = 1'b1;
      tick();
      go = 1'b0;
      #1;
      total++;
      if (pc_en !== 1'b1 || running !== 1'b1) begin
        bad++;
        $display("[TB] FAIL step_pulse %0d: pc_en=%b running=%b required 1/1", p, pc_en, running);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        #1;
        total++;
        if (pc_en !== 1'b0 || running !== 1'b0 || cnt_instr !== p) begin
          bad++;
          $display("[TB] FAIL step_after %0d.%0d: pc_en=%b running=%b instr=%0d required 0/0/%0d",
                   p, k, pc_en, running, cnt_instr, p);
        end
        tick();
      end
    end
    step_mode = 1'b0;
  endtask

  task automatic test_pause_resume();
    do_reset();
    step_mode = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    // A step_mode change during RUN must not matter
    step_mode = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    step_mode = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if (running !== 1'b0 || pc_en !== 1'b0 || cnt_instr !== 32'd7) begin
      bad++;
      $display("[TB] FAIL pause_hold: running=%b pc_en=%b instr=%0d required 0/0/7", running, pc_en, cnt_instr);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    #1;
    total++;
    if (pc_en !== 1'b1 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL resume_run: pc_en=%b running=%b required 1/1", pc_en, running);
    end
    tick();
    tick();
    #1;
    total++;
    if (cnt_instr !== 32'd9 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL resume_count: instr=%0d running=%b required 9/1", cnt_instr, running);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    step_mode = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    is_br_taken = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    is_br_taken = 1'b0;
    #1;
    total++;
    if (cnt_br4 !== 4'd15 || cnt_instr4 !== 4'd15 || cnt_jump4 !== 4'd0) begin
      bad++;
      $display("[TB] FAIL sat_4bit: br=%0d instr=%0d jump=%0d required 15/15/0", cnt_br4, cnt_instr4, cnt_jump4);
    end
    total++;
    if (cnt_br !== 32'd20 || cnt_instr !== 32'd20) begin
      bad++;
      $display("[TB] FAIL sat_32bit: br=%0d instr=%0d required 20/20", cnt_br, cnt_instr);
    end
    halt_req = 1'b1;
    go = 1'b1;
    #1;
    total++;
    if (pc_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL prio_pc_en: pc_en=%b required 0", pc_en);
    end
    tick();
    halt_req = 1'b0;
    go = 1'b0;
    #1;
    total++;
    if (halted !== 1'b1 || running !== 1'b0 || cnt_instr !== 32'd20) begin
      bad++;
      $display("[TB] FAIL prio_halt: halted=%b running=%b instr=%0d required 1/0/20", halted, running, cnt_instr);
    end
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    #1;
    total++;
    if (cnt_instr !== 32'd3 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrun_pre: instr=%0d running=%b required 3/1", cnt_instr, running);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    total++;
    if (running !== 1'b0 || halted !== 1'b0 || pc_en !== 1'b0 || cnt_instr !== 32'd0 || cnt_instr4 !== 4'd0) begin
      bad++;
      $display("[TB] FAIL midrun_clr: running=%b halted=%b pc_en=%b instr=%0d instr4=%0d required 0",
               running, halted, pc_en, cnt_instr, cnt_instr4);
    end
  endtask

`ifdef RUN_CTRL_BREAKPOINT_EN
  task automatic test_breakpoint();
    do_reset();
    step_mode = 1'b0;
    bp_addr  = 32'h0040_0010;
    bp_valid = 1'b1;
    pc       = 32'h0040_0000;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h0040_0000 + 32'(4 * i);
      #1;
      total++;
      if (pc_en !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_pre %0d: pc_en=%b required 1", i, pc_en);
      end
      tick();
    end
    pc = 32'h0040_0010;
    #1;
    total++;
    if (pc_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_trap: pc_en=%b required 0", pc_en);
    end
    tick();
    tick();
    #1;
    total++;
    if (running !== 1'b0 || cnt_instr !== 32'd4) begin
      bad++;
      $display("[TB] FAIL bp_pause: running=%b instr=%0d required 0/4", running, cnt_instr);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    #1;
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_resume: pc_en=%b required 1", pc_en);
    end
    tick();
    pc = 32'h0040_0014;
    #1;
    total++;
    if (cnt_instr !== 32'd5 || running !== 1'b1 || pc_en !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_continue: instr=%0d running=%b pc_en=%b required 5/1/1", cnt_instr, running, pc_en);
    end
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    clr = 1'b1; go = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
    is_jump = 1'b0; is_br_taken = 1'b0;
    pc = 32'h0; bp_addr = 32'h0; bp_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_halt();
    test_step();
    test_pause_resume();
    test_saturation();
`ifdef RUN_CTRL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Execution controller for the board-level single-cycle MIPS CPU.
- Sits directly upstream of the PC register and drives its write-enable, so the PC only advances when this block allows it.
- Handles run/pause/single-step from the board button and sticky halt on the exit syscall.
- Keeps saturating statistics counters (retired instructions, jumps, taken branches) for the display logic.

Parameters:
- CNT_W, 32, width of each statistics counter.
- ADDR_W, 32, PC width; used only when the breakpoint feature is compiled in.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset; sampled on the rising edge of clk.
- go  in  1  run/pause button level, already debounced and synchronous to clk.
- step_mode  in  1  when 1, a go press executes exactly one instruction.
- halt_req  in  1  combinational from the decoder; 1 while the current instruction is the exit syscall.
- is_jump  in  1  current instruction is an unconditional jump (j/jal/jr).
- is_br_taken  in  1  current instruction is a conditional branch that is taken.
- pc_en  out  1  write-enable to the PC register; 1 means the current instruction retires this cycle.
- running  out  1  state is RUN or STEP.
- halted  out  1  state is HALT.
- cnt_instr  out  CNT_W  retired-instruction count.
- cnt_jump  out  CNT_W  retired unconditional-jump count.
- cnt_br  out  CNT_W  retired taken-branch count.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high, on the clr port; clk is the single clock.
  - While clr=1 at a rising edge: state=IDLE, go_q=0, all counters 0. Outputs after that edge: pc_en=0, running=0, halted=0.
  - clr overrides every other input, including in HALT and in mid-RUN.
- Press detection: go_q is go registered once; press = go & ~go_q, a one-cycle pulse. A held button produces only one press.
- FSM states: IDLE(0), RUN(1), STEP(2), HALT(3).
  - IDLE: on press, go to STEP if step_mode=1, otherwise RUN. No press: stay.
  - RUN: halt_req=1 -> HALT. Else press -> IDLE (pause). Else stay. halt_req has priority over a simultaneous press.
  - STEP: always leaves after one cycle. halt_req=1 -> HALT, otherwise IDLE.
  - HALT: sticky. go is ignored; only clr leaves this state.
- pc_en:
  - Combinational: pc_en = (state==RUN | state==STEP) & ~halt_req.
  - Consequence: the syscall instruction never retires and the PC stays on it.
  - pc_en has 0 cycles latency from state; a state change takes effect the cycle after its triggering edge.
- Counters:
  - cnt_instr increments at the edge where pc_en=1.
  - cnt_jump increments when pc_en & is_jump; cnt_br increments when pc_en & is_br_taken.
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - Counters hold their value in IDLE and HALT and are readable at any time.
- step_mode is sampled only at a press in IDLE. Changing it during RUN has no effect until the next pause.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- Defined:
  - Adds input ports pc (ADDR_W), bp_addr (ADDR_W) and bp_valid (1).
  - In RUN, if bp_valid & pc==bp_addr & ~skip_bp, then pc_en=0 that cycle and the next state is IDLE. The breakpoint instruction has not retired and no counters increment.
  - skip_bp is a register set on the press that leaves IDLE and cleared after the first cycle spent in RUN/STEP. The instruction at the breakpoint therefore executes on resume instead of re-trapping.
  - halt_req has priority over a breakpoint. STEP ignores breakpoints.
  - clr clears skip_bp.
- Undefined: no extra ports or logic; behaviour exactly as above.

Decomposition:
- Shared package run_ctrl_pkg:
  - state typedef and encodings IDLE/RUN/STEP/HALT.
  - default CNT_W.
- One natural sub-module, sat_counter: parameter W; ports clk, clr, inc, q; saturating at all-ones. Instantiated three times.

Test Plan:
1. Reset then idle: clr=1 for 2 cycles, then 0; no press for 10 cycles -> pc_en=0, running=0, all counters 0.
2. Run and halt: step_mode=0, go held high 5 cycles (one press), is_jump=1 on 3 of the retiring cycles, halt_req=1 on the 20th RUN cycle -> single press only, cnt_instr=19, cnt_jump=3, halted=1, pc_en=0 while halt_req=1. Further go presses leave halted=1.
3. Single-step: step_mode=1, three separate presses -> exactly three one-cycle pc_en pulses, cnt_instr=3, state IDLE after each.
4. Pause/resume: press in RUN after 7 retired instructions -> IDLE with cnt_instr=7 holding; next press resumes counting from 8.
5. Saturation and priority: CNT_W=4, 20 retiring cycles with is_br_taken=1 -> cnt_br=15 and cnt_instr=15 stay at 15. halt_req and press in the same RUN cycle -> HALT. clr asserted mid-RUN -> IDLE with counters 0.
6. Breakpoint (RUN_CTRL_BREAKPOINT_EN): bp_addr=0x0040_0010, bp_valid=1, pc stepping by 4 from 0x0040_0000 -> pause with cnt_instr=4. Next press -> the instruction at 0x0040_0010 retires (cnt_instr=5) and RUN continues.
